// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and helpers for the data-memory responder
//
// Purpose : access-size encodings (funct3), FSM state encoding, wait-counter
//           width, plus size legality and load-extension helpers.
// Ports   : none (package).
package dmem_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  function automatic logic size_legal(input logic [2:0] size);
    case (size)
      SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then sign- or zero-extend.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  size);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (size)
      SZ_B:    return {{24{sh[7]}}, sh[7:0]};
      SZ_BU:   return {24'h0, sh[7:0]};
      SZ_H:    return {{16{sh[15]}}, sh[15:0]};
      SZ_HU:   return {16'h0, sh[15:0]};
      SZ_W:    return sh;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram_array.sv
// rtl/dmem_ram_array.sv - single-port word RAM with four byte enables
//
// Purpose : DEPTH_WORDS x 32 storage. Writes are synchronous with per-byte
//           enables; the read port is combinational so the responder can
//           register extended load data on the same edge it enters RESP.
//           Contents are not reset.
// Ports   : clk    in  clock
//           we     in  write strobe for this cycle
//           be     in  4 byte enables (bit i -> bits 8i+7:8i)
//           addr   in  word index
//           wdata  in  lane-replicated write data
//           rdata  out word currently stored at addr
module dmem_ram_array #(
  parameter int DEPTH_WORDS = 256,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] word_d;

  assign rdata = mem_q[addr];

  // Merge enabled bytes of wdata over the current word.
  always_comb begin
    word_d = mem_q[addr];
    for (int i = 0; i < 4; i++) begin
      if (be[i]) word_d[i*8 +: 8] = wdata[i*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= word_d;
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - RV32I data-memory responder with wait states
//
// Purpose : accepts load/store requests over valid/ready, waits WAIT_STATES
//           cycles, accesses RAM on the edge entering RESP and returns a
//           one-cycle response with extended load data and an error flag.
// Config  : DMEM_MISALIGN_CHECK_EN - when defined, misaligned H/HU/W accesses
//           raise rsp_err and stores are suppressed; otherwise the low
//           address bits are forced to alignment.
// Ports   : clk, reset (sync, active-high)
//           req_valid/req_ready handshake; req_we, req_addr, req_wdata,
//           req_size (funct3) request fields
//           rsp_valid one-cycle pulse; rsp_rdata, rsp_err registered result
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_size,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  we_q, we_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [2:0]            size_q, size_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;

  logic                  acc_we;
  logic [31:0]           acc_addr, acc_wdata, eff_addr;
  logic [2:0]            acc_size;
  logic                  acc_err;
  logic                  access;
  logic                  ram_we;
  logic [3:0]            ram_be;
  logic [31:0]           ram_wdata, ram_rdata;
  logic                  unused_addr_bits;

  // With zero wait states the access happens on the accepting edge, before
  // the request is latched, so IDLE uses the live request fields.
  always_comb begin
    if (state_q == ST_IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_size  = req_size;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_size  = size_q;
    end
  end

  always_comb begin
    eff_addr = acc_addr;
`ifdef DMEM_MISALIGN_CHECK_EN
    acc_err = !size_legal(acc_size) ||
              (((acc_size == SZ_H) || (acc_size == SZ_HU)) && acc_addr[0]) ||
              ((acc_size == SZ_W) && (acc_addr[1:0] != 2'b00));
`else
    acc_err = !size_legal(acc_size);
    if ((acc_size == SZ_H) || (acc_size == SZ_HU)) eff_addr[0] = 1'b0;
    else if (acc_size == SZ_W)                     eff_addr[1:0] = 2'b00;
`endif
  end

  // Byte enables and lane replication for stores.
  always_comb begin
    ram_be    = 4'b0000;
    ram_wdata = 32'h0;
    case (acc_size)
      SZ_B, SZ_BU: begin
        ram_be    = 4'b0001 << eff_addr[1:0];
        ram_wdata = {4{acc_wdata[7:0]}};
      end
      SZ_H, SZ_HU: begin
        ram_be    = eff_addr[1] ? 4'b1100 : 4'b0011;
        ram_wdata = {2{acc_wdata[15:0]}};
      end
      SZ_W: begin
        ram_be    = 4'b1111;
        ram_wdata = acc_wdata;
      end
      default: begin
        ram_be    = 4'b0000;
        ram_wdata = 32'h0;
      end
    endcase
  end

  // Upper address bits alias and are intentionally ignored.
  assign unused_addr_bits = ^eff_addr[31:AW+2];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    size_d      = size_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    access      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          cnt_d   = WAIT_CNT_W'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
            access  = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - WAIT_CNT_W'(1);
        if (cnt_q == WAIT_CNT_W'(1)) begin
          state_d = ST_RESP;
          access  = 1'b1;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (access) begin
      rsp_err_d   = acc_err;
      rsp_rdata_d = (acc_we || acc_err) ? 32'h0
                                        : load_extend(ram_rdata, eff_addr[1:0], acc_size);
    end
  end

  // A reset on the entering edge abandons the transaction, so it also
  // blocks the write.
  assign ram_we = access && acc_we && !acc_err && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      size_q      <= 3'b000;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      size_q      <= size_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  dmem_ram_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .be   (ram_be),
    .addr (eff_addr[AW+1:2]),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Index 0: WAIT_STATES=1 instance, index 1: WAIT_STATES=3 instance.
  logic        reset     [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [2:0]  req_size  [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(1)) u_dut1 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_size(req_size[0]), .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0])
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_size(req_size[1]), .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1])
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one request, wait for acceptance and the response pulse.
  // lat = cycles from the accepting cycle to the rsp_valid cycle.
  task automatic xact(input int d, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] size,
                      output logic [31:0] rdata, output logic err, output int lat);
    int guard;
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_size[d]  = size;
    guard = 0;
    while (!req_ready[d] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check_eq("accept_timeout", {31'b0, req_ready[d]}, 32'd1);
    @(negedge clk);
    req_valid[d] = 1'b0;
    lat = 1;
    while (!rsp_valid[d] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 20) check_eq("rsp_timeout", {31'b0, rsp_valid[d]}, 32'd1);
    rdata = rsp_rdata[d];
    err   = rsp_err[d];
  endtask

  task automatic load_chk(input int d, input string tag, input logic [31:0] addr,
                          input logic [2:0] size, input logic [31:0] exp_data,
                          input logic exp_err);
    logic [31:0] rd;
    logic        er;
    int          lat;
    xact(d, 1'b0, addr, 32'h0, size, rd, er, lat);
    check_eq({tag, "_data"}, rd, exp_data);
    check_eq({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          pulses;

  initial begin
    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0;
      req_addr[d] = 32'h0; req_wdata[d] = 32'h0; req_size[d] = 3'b010;
    end
    repeat (3) @(negedge clk);
    check_eq("rst_ready", {31'b0, req_ready[0]}, 32'd1);
    check_eq("rst_rsp_valid", {31'b0, rsp_valid[0]}, 32'd0);
    check_eq("rst_rdata", rsp_rdata[0], 32'h0);
    check_eq("rst_err", {31'b0, rsp_err[0]}, 32'd0);
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    @(negedge clk);
    check_eq("idle_ready", {31'b0, req_ready[0]}, 32'd1);
    check_eq("idle_rsp_valid", {31'b0, rsp_valid[0]}, 32'd0);

    // ---- WAIT_STATES=1 instance ----
    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'b010, rd, er, lat);
    check_eq("sw_latency", lat, 32'd2);
    check_eq("sw_err", {31'b0, er}, 32'd0);
    check_eq("sw_rdata", rd, 32'h0);
    @(negedge clk);
    check_eq("pulse_drop", {31'b0, rsp_valid[0]}, 32'd0);
    check_eq("ready_back", {31'b0, req_ready[0]}, 32'd1);

    load_chk(0, "lw_10",  32'h10, 3'b010, 32'hDEADBEEF, 1'b0);
    @(negedge clk);
    check_eq("rdata_hold", rsp_rdata[0], 32'hDEADBEEF);
    load_chk(0, "lb_13",  32'h13, 3'b000, 32'hFFFFFFDE, 1'b0);
    load_chk(0, "lbu_13", 32'h13, 3'b100, 32'h000000DE, 1'b0);
    load_chk(0, "lh_12",  32'h12, 3'b001, 32'hFFFFDEAD, 1'b0);
    load_chk(0, "lhu_10", 32'h10, 3'b101, 32'h0000BEEF, 1'b0);
    load_chk(0, "lbu_11", 32'h11, 3'b100, 32'h000000BE, 1'b0);

    xact(0, 1'b1, 32'h11, 32'h000000AA, 3'b000, rd, er, lat);
    check_eq("sb_err", {31'b0, er}, 32'd0);
    load_chk(0, "lw_after_sb", 32'h10, 3'b010, 32'hDEADAAEF, 1'b0);
    load_chk(0, "lw_alias", 32'h410, 3'b010, 32'hDEADAAEF, 1'b0);

`ifdef DMEM_MISALIGN_CHECK_EN
    load_chk(0, "lw_11_mis", 32'h11, 3'b010, 32'h0, 1'b1);
    load_chk(0, "lh_13_mis", 32'h13, 3'b001, 32'h0, 1'b1);
    xact(0, 1'b1, 32'h12, 32'h00005555, 3'b010, rd, er, lat);
    check_eq("sw_mis_err", {31'b0, er}, 32'd1);
    load_chk(0, "lw_after_mis", 32'h10, 3'b010, 32'hDEADAAEF, 1'b0);
`else
    load_chk(0, "lw_11_align", 32'h11, 3'b010, 32'hDEADAAEF, 1'b0);
    load_chk(0, "lh_13_align", 32'h13, 3'b001, 32'hFFFFDEAD, 1'b0);
`endif

    // Illegal sizes: error, zero data, no write.
    xact(0, 1'b1, 32'h10, 32'h0, 3'b011, rd, er, lat);
    check_eq("sz011_err", {31'b0, er}, 32'd1);
    check_eq("sz011_rdata", rd, 32'h0);
    load_chk(0, "sz111_load", 32'h10, 3'b111, 32'h0, 1'b1);
    load_chk(0, "lw_after_illegal", 32'h10, 3'b010, 32'hDEADAAEF, 1'b0);

    xact(0, 1'b1, 32'h12, 32'h00001234, 3'b001, rd, er, lat);
    load_chk(0, "lw_after_sh", 32'h10, 3'b010, 32'h1234AAEF, 1'b0);

    // Reset together with req_valid: not accepted, no response.
    @(negedge clk);
    reset[0] = 1'b1; req_valid[0] = 1'b1; req_we[0] = 1'b0;
    req_addr[0] = 32'h10; req_size[0] = 3'b010;
    @(negedge clk);
    reset[0] = 1'b0; req_valid[0] = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid[0]) pulses++;
    end
    check_eq("rst_req_no_rsp", pulses, 32'd0);

    // ---- WAIT_STATES=3 instance ----
    xact(1, 1'b1, 32'h20, 32'h11111111, 3'b010, rd, er, lat);
    check_eq("w3_latency", lat, 32'd4);
    load_chk(1, "w3_lw_20", 32'h20, 3'b010, 32'h11111111, 1'b0);

    // Reset two cycles after acceptance abandons the store.
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_addr[1] = 32'h20;
    req_wdata[1] = 32'h12345678; req_size[1] = 3'b010;
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    reset[1] = 1'b1;
    @(negedge clk);
    reset[1] = 1'b0;
    check_eq("w3_rst_ready", {31'b0, req_ready[1]}, 32'd1);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid[1]) pulses++;
    end
    check_eq("w3_abandon_no_rsp", pulses, 32'd0);
    load_chk(1, "w3_lw_prior", 32'h20, 3'b010, 32'h11111111, 1'b0);

    // req_valid held through the busy window is accepted once.
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h20; req_size[1] = 3'b010;
    pulses = 0;
    for (int c = 1; c <= 13; c++) begin
      @(negedge clk);
      if (rsp_valid[1]) begin
        pulses++;
        check_eq("w3_hold_rdata", rsp_rdata[1], 32'h11111111);
        check_eq("w3_hold_cycle", c, 32'd4);
      end
      if (c == 5) req_valid[1] = 1'b0;
    end
    check_eq("w3_hold_once", pulses, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
